// File: rtl/comparador_serial_der_izq_if.sv
// Handshake and operand bundle for the bit-serial comparator.
// The master drives the request and operands. The slave returns busy, done and f.
interface comparador_serial_der_izq_if #(
    parameter int unsigned N = 3
);
    logic         start;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         z;
    logic         y;
    logic         busy;
    logic         done;
    logic         f;

    modport master (
        output start, A, B, z, y,
        input  busy, done, f
    );

    modport slave (
        input  start, A, B, z, y,
        output busy, done, f
    );
endinterface

// File: rtl/comparador_serial_der_izq.sv
// Bit-serial magnitude comparator. It scans the operands LSB first, one bit per clock,
// and reports f after N cycles. Define COMPARE_SIGNED_EN to treat the operands as two's complement.
module comparador_serial_der_izq #(
    parameter int unsigned N = 3
) (
    input logic                        clk,
    input logic                        rst_n,
    comparador_serial_der_izq_if.slave bus
);
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LastCnt = CW'(N - 1);

    typedef enum logic {StIdle, StShift} state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  a_q, a_d, b_q, b_d;
    logic [1:0]    mode_q, mode_d;
    logic          gt_q, gt_d, lt_q, lt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d, f_q, f_d;

    logic bit_a, bit_b, last, gt_n, lt_n, f_sel;

    always_comb begin
        bit_a = a_q[cnt_q];
        bit_b = b_q[cnt_q];
        last  = (cnt_q == LastCnt);
        gt_n  = gt_q;
        lt_n  = lt_q;
        // Later (higher) bits overwrite the decision made by lower ones.
        if (bit_a != bit_b) begin
`ifdef COMPARE_SIGNED_EN
            gt_n = last ? bit_b : bit_a;
`else
            gt_n = bit_a;
`endif
            lt_n = ~gt_n;
        end

        unique case (mode_q)
            2'b00:   f_sel = ~(gt_n | lt_n);
            2'b01:   f_sel = gt_n;
            2'b10:   f_sel = lt_n;
            default: f_sel = gt_n | lt_n;
        endcase
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        mode_d  = mode_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        f_d     = f_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StShift;
                    a_d     = bus.A;
                    b_d     = bus.B;
                    mode_d  = {bus.z, bus.y};
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    cnt_d   = '0;
                end
            end
            StShift: begin
                gt_d = gt_n;
                lt_d = lt_n;
                if (last) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    f_d     = f_sel;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= '0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            f_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mode_q  <= mode_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            f_q     <= f_d;
        end
    end

    assign bus.busy = (state_q == StShift);
    assign bus.done = done_q;
    assign bus.f    = f_q;
endmodule

// File: tb/tb_comparador_serial_der_izq.sv
// Self-checking bench for comparador_serial_der_izq. It applies table vectors, corner sequences,
// an exhaustive sweep and random operations, and checks them against an arithmetic reference.
module tb_comparador_serial_der_izq;
    localparam int unsigned N = 3;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic prev_f = 1'b0;

    always #5 clk = ~clk;

    comparador_serial_der_izq_if #(.N(N)) bus ();

    comparador_serial_der_izq #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [1:0]   m;
        logic         exp_u;
        logic         exp_s;
    } vec_t;

    vec_t vecs[12];

    function automatic logic ref_f(input logic [N-1:0] a, input logic [N-1:0] b,
                                   input logic [1:0] m);
        logic gt, lt;
`ifdef COMPARE_SIGNED_EN
        gt = $signed(a) > $signed(b);
        lt = $signed(a) < $signed(b);
`else
        gt = a > b;
        lt = a < b;
`endif
        case (m)
            2'b00:   return a == b;
            2'b01:   return gt;
            2'b10:   return lt;
            default: return a != b;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One full operation. The inputs are scrambled, and start is pulsed at random, while busy.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic [1:0] m,
                          input logic exp_f, input string name);
        int e;
        @(negedge clk);
        bus.start = 1'b1;
        bus.A = a;
        bus.B = b;
        {bus.z, bus.y} = m;
        @(negedge clk);
        chk({name, " busy_after_start"}, 32'(bus.busy), 32'd1);
        chk({name, " f_held"}, 32'(bus.f), 32'(prev_f));
        e = 0;
        while (bus.done !== 1'b1 && e < 4 * N) begin
            bus.start = 1'($urandom);
            bus.A = N'($urandom);
            bus.B = N'($urandom);
            {bus.z, bus.y} = 2'($urandom);
            @(negedge clk);
            e++;
            if (e < N) chk({name, " busy_mid"}, 32'(bus.busy), 32'd1);
        end
        bus.start = 1'b0;
        chk({name, " latency"}, 32'(e), 32'(N));
        chk({name, " done"}, 32'(bus.done), 32'd1);
        chk({name, " busy_at_done"}, 32'(bus.busy), 32'd0);
        chk({name, " f"}, 32'(bus.f), 32'(exp_f));
        prev_f = exp_f;
        @(negedge clk);
        chk({name, " done_one_cycle"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        vecs[0]  = '{3'd6, 3'd6, 2'b00, 1'b1, 1'b1};
        vecs[1]  = '{3'd6, 3'd6, 2'b01, 1'b0, 1'b0};
        vecs[2]  = '{3'd6, 3'd6, 2'b10, 1'b0, 1'b0};
        vecs[3]  = '{3'd6, 3'd6, 2'b11, 1'b0, 1'b0};
        vecs[4]  = '{3'd2, 3'd6, 2'b00, 1'b0, 1'b0};
        vecs[5]  = '{3'd2, 3'd6, 2'b01, 1'b0, 1'b1};
        vecs[6]  = '{3'd2, 3'd6, 2'b10, 1'b1, 1'b0};
        vecs[7]  = '{3'd2, 3'd6, 2'b11, 1'b1, 1'b1};
        vecs[8]  = '{3'd3, 3'd4, 2'b01, 1'b0, 1'b1};
        vecs[9]  = '{3'd3, 3'd4, 2'b10, 1'b1, 1'b0};
        vecs[10] = '{3'd5, 3'd3, 2'b01, 1'b1, 1'b0};
        vecs[11] = '{3'd5, 3'd3, 2'b10, 1'b0, 1'b1};

        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.A = '0;
        bus.B = '0;
        bus.z = 1'b0;
        bus.y = 1'b0;
        #12;
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        chk("reset f", 32'(bus.f), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
`ifdef COMPARE_SIGNED_EN
            run_op(vecs[i].a, vecs[i].b, vecs[i].m, vecs[i].exp_s, $sformatf("vec%0d", i));
`else
            run_op(vecs[i].a, vecs[i].b, vecs[i].m, vecs[i].exp_u, $sformatf("vec%0d", i));
`endif
        end

        // A start pulse during SHIFT with other operands must be ignored.
        @(negedge clk);
        bus.start = 1'b1;
        bus.A = 3'd5;
        bus.B = 3'd3;
        {bus.z, bus.y} = 2'b01;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.A = 3'd0;
        bus.B = 3'd7;
        {bus.z, bus.y} = 2'b00;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        chk("ignore done", 32'(bus.done), 32'd1);
        chk("ignore f", 32'(bus.f), 32'(ref_f(3'd5, 3'd3, 2'b01)));
        prev_f = ref_f(3'd5, 3'd3, 2'b01);
        @(negedge clk);
        chk("ignore no_second_op", 32'(bus.busy), 32'd0);

        // Reset asserted mid-operation aborts without a done pulse.
        run_op(3'd4, 3'd1, 2'b11, 1'b1, "pre_reset");
        @(negedge clk);
        bus.start = 1'b1;
        bus.A = 3'd5;
        bus.B = 3'd3;
        {bus.z, bus.y} = 2'b01;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort busy", 32'(bus.busy), 32'd0);
        chk("abort done", 32'(bus.done), 32'd0);
        chk("abort f", 32'(bus.f), 32'd0);
        prev_f = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort no_done", 32'(bus.done), 32'd0);
        end
        run_op(3'd5, 3'd3, 2'b01, ref_f(3'd5, 3'd3, 2'b01), "rerun");

        // With start held high, operations run back to back, one every N+1 cycles.
        @(negedge clk);
        bus.start = 1'b1;
        bus.A = 3'd1;
        bus.B = 3'd0;
        {bus.z, bus.y} = 2'b01;
        @(negedge clk);
        bus.A = 3'd0;
        bus.B = 3'd1;
        for (int e = 1; e <= 2 * N + 1; e++) begin
            @(negedge clk);
            if (e == 2 * N + 1) bus.start = 1'b0;
            chk($sformatf("b2b done e%0d", e), 32'(bus.done),
                32'((e == N) || (e == 2 * N + 1)));
            if (e >= N && e <= 2 * N) chk($sformatf("b2b f1 e%0d", e), 32'(bus.f), 32'd1);
            if (e == 2 * N + 1) chk("b2b f2", 32'(bus.f), 32'd0);
        end
        prev_f = 1'b0;
        repeat (2) @(negedge clk);
        chk("b2b idle", 32'(bus.busy), 32'd0);

        for (int a = 0; a < (1 << N); a++)
            for (int b = 0; b < (1 << N); b++)
                for (int m = 0; m < 4; m++)
                    run_op(N'(a), N'(b), 2'(m), ref_f(N'(a), N'(b), 2'(m)),
                           $sformatf("sweep a%0d b%0d m%0d", a, b, m));

        for (int i = 0; i < 40; i++) begin
            logic [N-1:0] ra, rb;
            logic [1:0]   rm;
            ra = N'($urandom);
            rb = N'($urandom);
            rm = 2'($urandom_range(0, 3));
            run_op(ra, rb, rm, ref_f(ra, rb, rm), $sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
